dwt_upsample_m: RTL and testbench



---
 rtl/dwt_pkg.sv | 35 +++
 rtl/dwt_width_conv.sv | 20 ++
 rtl/dwt_upsample_m.sv | 83 ++++++++
 tb/tb_dwt_upsample_m.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Shared DWT definitions: mode/saturation selectors and the signed width converter.
package dwt_pkg;

  localparam int MODE_ZERO = 0;
  localparam int MODE_HOLD = 1;
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Widest sample the converter handles; callers sign-extend into this.
  localparam int CONV_W = 64;

  // Reduce a sign-extended sample to dout_w signed bits. The result comes back
  // sign-extended to CONV_W so the caller just truncates. clip flags any value
  // outside the signed dout_w range, in both wrap and clamp modes.
  function automatic logic signed [CONV_W-1:0] width_conv(
    input  logic signed [CONV_W-1:0] x,
    input  int                       dout_w,
    input  logic                     clamp,
    output logic                     clip
  );
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    hi   = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo   = ~hi;
    clip = (x > hi) || (x < lo);
    if (!clip)
      width_conv = x;
    else if (clamp)
      width_conv = x[CONV_W-1] ? lo : hi;
    else
      // keep the sign bit, wrap the magnitude into the low dout_w-1 bits
      width_conv = x[CONV_W-1] ? (x | lo) : (x & hi);
  endfunction

endpackage

// File: rtl/dwt_width_conv.sv
// Combinational signed width reduction with clip detect (wrap or saturate).
module dwt_width_conv
  import dwt_pkg::*;
#(
  parameter int DIN_W  = 40,
  parameter int DOUT_W = 25,
  parameter int SAT    = SAT_WRAP
) (
  input  logic signed [DIN_W-1:0]  din,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     clip
);

  // Equal widths fall out as a pass-through: nothing is ever out of range.
  always_comb begin
    clip = 1'b0;
    dout = DOUT_W'(width_conv(64'(din), DOUT_W, SAT == SAT_CLAMP, clip));
  end

endmodule

// File: rtl/dwt_upsample_m.sv
// Integer-factor upsampler: each accepted sample becomes FACTOR output beats,
// zero-stuffed or held, after width reduction to the next filter's precision.
module dwt_upsample_m
  import dwt_pkg::*;
#(
  parameter int DIN_W  = 40,
  parameter int DOUT_W = 25,
  parameter int FACTOR = 2,
  parameter int PHASE  = 0,
  parameter int MODE   = MODE_ZERO,
  parameter int SAT    = SAT_WRAP
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DOUT_W-1:0] out_data,
  output logic                     out_last,
  output logic                     sat_flag,
  input  logic                     sat_clr
);

  localparam int              CW   = $clog2(FACTOR);
  localparam logic [CW-1:0]   LAST = CW'(FACTOR - 1);
  localparam logic [CW-1:0]   PH   = CW'(PHASE);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state, state_nx;
  logic [CW-1:0]             cnt, cnt_nx;
  logic signed [DOUT_W-1:0]  hold_q;
  logic signed [DOUT_W-1:0]  conv;
  logic                      clip;
  logic                      accept;
  logic                      at_last;

  dwt_width_conv #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .SAT(SAT)) u_conv (
    .din  (in_data),
    .dout (conv),
    .clip (clip)
  );

  assign out_valid = (state == EMIT);
  assign at_last   = (cnt == LAST);
  // Taking a new sample on the last beat's handshake keeps groups bubble-free.
  assign in_ready  = !out_valid || (out_ready && at_last);
  assign accept    = in_valid && in_ready;
  assign out_last  = out_valid && at_last;
  assign out_data  = (out_valid && (MODE == MODE_HOLD || cnt == PH)) ? hold_q : '0;

  // Next state / beat counter; a stalled beat leaves everything as is.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (accept) begin
      state_nx = EMIT;
      cnt_nx   = '0;
    end else if (out_valid && out_ready) begin
      if (at_last) state_nx = IDLE;
      else         cnt_nx   = cnt + 1'b1;
    end
  end

  // State, counter, hold register and sticky clip flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_q   <= '0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) hold_q <= conv;
      if (accept && clip) sat_flag <= 1'b1;
      else if (sat_clr)   sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwt_upsample_m.sv
// Bench for dwt_upsample_m: four configurations share one stimulus stream and
// are each checked every cycle against a queue-of-beats reference model.
module tb_dwt_upsample_m;

  localparam int N = 4;
  localparam int FAC [N] = '{2, 3, 4, 2};
  localparam int PHS [N] = '{0, 0, 2, 0};
  localparam int MOD [N] = '{0, 1, 0, 1};
  localparam int STW [N] = '{1, 0, 0, 1};
  localparam int IW  [N] = '{40, 40, 40, 25};
  localparam int OW = 25;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  in_valid = 1'b0;
  logic signed [39:0]    in_data = '0;
  logic                  out_ready = 1'b0;
  logic                  sat_clr = 1'b0;
  logic [N-1:0]          in_ready, out_valid, out_last, sat_flag;
  logic signed [OW-1:0]  out_data [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dwt_upsample_m #(
      .DIN_W(IW[g]), .DOUT_W(OW), .FACTOR(FAC[g]),
      .PHASE(PHS[g]), .MODE(MOD[g]), .SAT(STW[g])
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready[g]), .in_data(in_data[IW[g]-1:0]),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_data(out_data[g]), .out_last(out_last[g]),
      .sat_flag(sat_flag[g]), .sat_clr(sat_clr)
    );
  end

  // Reference model: the beats still owed by each instance, in order.
  longint qd [N][$];
  bit     ql [N][$];
  bit     mflag [N];
  int     vecs = 0;
  int     miss = 0;

  function automatic longint ref_conv(input longint x, input int ow, input int sat, output bit clip);
    longint m;
    m    = longint'(1) << (ow - 1);
    clip = (x >= m) || (x < -m);
    if (!clip) return x;
    if (sat != 0) return (x < 0) ? -m : m - 1;
    return (x < 0) ? (((x % m) + m) % m) - m : x % m;
  endfunction

  function automatic longint src(input int i);
    logic signed [24:0] t;
    t = in_data[24:0];
    return (IW[i] == 40) ? longint'(in_data) : longint'(t);
  endfunction

  task automatic chk(input string tag, input int i, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s[%0d] got %0d expected %0d at %0t", tag, i, obs, exp, $time);
    end
  endtask

  // Compare on the falling edge, advance the model, then cross the rising edge.
  task automatic tick();
    int  sz;
    bit  rdy, acc, clip;
    longint v;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      sz = qd[i].size();
      chk("out_valid", i, 64'(out_valid[i]), sz > 0);
      chk("in_ready",  i, 64'(in_ready[i]), (sz == 0) || (out_ready && sz == 1));
      chk("out_data",  i, 64'(out_data[i]), (sz > 0) ? qd[i][0] : 0);
      chk("out_last",  i, 64'(out_last[i]), (sz > 0) && ql[i][0]);
      chk("sat_flag",  i, 64'(sat_flag[i]), mflag[i]);
    end
    for (int i = 0; i < N; i++) begin
      if (!rstn) begin
        qd[i].delete(); ql[i].delete(); mflag[i] = 0;
      end else begin
        sz  = qd[i].size();
        rdy = (sz == 0) || (out_ready && sz == 1);
        acc = in_valid && rdy;
        clip = 0;
        if (sz > 0 && out_ready) begin
          void'(qd[i].pop_front()); void'(ql[i].pop_front());
        end
        if (acc) begin
          v = ref_conv(src(i), OW, STW[i], clip);
          for (int k = 0; k < FAC[i]; k++) begin
            qd[i].push_back((MOD[i] == 1 || k == PHS[i]) ? v : 0);
            ql[i].push_back(k == FAC[i] - 1);
          end
        end
        if (acc && clip) mflag[i] = 1;
        else if (sat_clr) mflag[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iv, input longint d, input bit ordy, input bit clr);
    in_valid  = iv;
    in_data   = 40'(d);
    out_ready = ordy;
    sat_clr   = clr;
    tick();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0);
  endtask

  initial begin
    longint r;
    for (int i = 0; i < N; i++) mflag[i] = 0;
    tick(); tick();
    rstn = 1'b1;

    // back-to-back samples, no backpressure
    step(1, 5, 1, 0);
    step(1, -3, 1, 0);
    drain(8);
    // single sample with out_ready toggling
    step(1, 7, 1, 0);
    for (int k = 0; k < 10; k++) step(0, 0, k[0], 0);
    drain(5);
    // phase placement
    step(1, 100, 1, 0);
    drain(6);
    // clipping in both directions, then a clean value
    step(1, 64'sd1 <<< 30, 1, 0);
    drain(6);
    step(1, -(64'sd1 <<< 30), 1, 0);
    drain(6);
    step(0, 0, 1, 1);
    step(1, 1000, 1, 0);
    drain(6);
    // clip and clear together: set wins; clear alone afterwards
    step(1, 64'sd1 <<< 30, 1, 1);
    step(0, 0, 1, 1);
    drain(6);
    // reset in the middle of a group
    step(1, 9, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rstn = 1'b0;
    step(0, 0, 1, 0);
    rstn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 2, 64'(out_valid[2]), 0);
    chk("rst_out_data",  2, 64'(out_data[2]), 0);
    chk("rst_in_ready",  2, 64'(in_ready[2]), 1);
    @(posedge clk);
    #1;
    step(1, 11, 1, 0);
    drain(6);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(2))
        0:       r = longint'($urandom_range(0, 33554431)) - 16777216;
        1:       r = longint'({$urandom, $urandom});
        default: r = ($urandom_range(1) != 0) ? 16777215 + longint'($urandom_range(2))
                                             : -16777216 - longint'($urandom_range(2));
      endcase
      rstn = ($urandom_range(63) != 0);
      step($urandom_range(1) != 0, r, $urandom_range(3) != 0, $urandom_range(7) == 0);
    end
    rstn = 1'b1;
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
